// File: rtl/ys_poly_small_inv3.sv
// Inverse of the mode-3 small-polynomial transform: g[i] = g[i-1] - h[i]*3^-1 (mod 2^13),
// streamed 8 coefficients per cycle from ram1 into ram2 through a 3-stage pipeline.
module ys_poly_small_inv3 #(
  parameter int NTRU_N  = 509,
  parameter int AW      = 7,
  parameter int N_PAIRS = (NTRU_N + 7) / 8,
  localparam int DW_PH  = 52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ram1_addra,
  output logic [AW-1:0]    ram1_addrb,
  input  logic [DW_PH-1:0] ram1_douta,
  input  logic [DW_PH-1:0] ram1_doutb,
  output logic [AW-1:0]    ram2_addra,
  output logic [AW-1:0]    ram2_addrb,
  output logic             ram2_wea,
  output logic             ram2_web,
  output logic [DW_PH-1:0] ram2_dina,
  output logic [DW_PH-1:0] ram2_dinb
);

  localparam int CW = 13;
  localparam int KW = AW - 1;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t           state_reg;
  logic [KW-1:0]    k_reg;
  logic [1:0]       flush_cnt_reg;
  logic [CW-1:0]    acc_reg;
  logic             busy_reg;
  logic             done_reg;

  // Pipeline tags: stage 1 marks the cycle ram1 data is present, stage 2 holds q.
  logic             v1_reg;
  logic             v2_reg;
  logic [KW-1:0]    k1_reg;
  logic [KW-1:0]    k2_reg;
  logic [CW-1:0]    q_reg  [8];
  logic [CW-1:0]    q_next [8];
  logic [CW-1:0]    g_next [8];

  logic [AW-1:0]    wr_addra_reg;
  logic [AW-1:0]    wr_addrb_reg;
  logic             wea_reg;
  logic             web_reg;
  logic [DW_PH-1:0] dina_reg;
  logic [DW_PH-1:0] dinb_reg;
  logic [DW_PH-1:0] dina_next;
  logic [DW_PH-1:0] dinb_next;

  assign ram1_addra = {k_reg, 1'b0};
  assign ram1_addrb = {k_reg, 1'b1};
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ram2_addra = wr_addra_reg;
  assign ram2_addrb = wr_addrb_reg;
  assign ram2_wea   = wea_reg;
  assign ram2_web   = web_reg;
  assign ram2_dina  = dina_reg;
  assign ram2_dinb  = dinb_reg;

  // 2731 = 2048+512+128+32+8+2+1; shifted terms are pre-truncated to 13 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [CW-1:0] h;
      if (gi < 4) begin : g_lo
        assign h = ram1_douta[CW*gi +: CW];
      end else begin : g_hi
        assign h = ram1_doutb[CW*(gi-4) +: CW];
      end
      assign q_next[gi] = h + {h[11:0], 1'b0} + {h[9:0], 3'b0} + {h[7:0], 5'b0}
                        + {h[5:0], 7'b0} + {h[3:0], 9'b0} + {h[1:0], 11'b0};
    end
  endgenerate

  // Running difference across the 8 lanes; lanes past NTRU_N are forced to zero.
  always_comb begin
    logic [CW-1:0] run;
    run       = acc_reg;
    dina_next = '0;
    dinb_next = '0;
    for (int j = 0; j < 8; j++) begin
      run       = run - q_reg[j];
      g_next[j] = run;
      if (int'({k2_reg, 3'(j)}) < NTRU_N) begin
        if (j < 4) dina_next[CW*j +: CW] = run;
        else       dinb_next[CW*(j-4) +: CW] = run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      flush_cnt_reg <= '0;
      acc_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      k1_reg        <= '0;
      k2_reg        <= '0;
      for (int j = 0; j < 8; j++) q_reg[j] <= '0;
      wr_addra_reg  <= '0;
      wr_addrb_reg  <= '0;
      wea_reg       <= 1'b0;
      web_reg       <= 1'b0;
      dina_reg      <= '0;
      dinb_reg      <= '0;
    end else begin
      v1_reg  <= (state_reg == READ);
      k1_reg  <= k_reg;
      v2_reg  <= v1_reg;
      k2_reg  <= k1_reg;
      if (v1_reg) q_reg <= q_next;

      wea_reg <= v2_reg;
      web_reg <= v2_reg;
      if (v2_reg) begin
        wr_addra_reg <= {k2_reg, 1'b0};
        wr_addrb_reg <= {k2_reg, 1'b1};
        dina_reg     <= dina_next;
        dinb_reg     <= dinb_next;
        acc_reg      <= g_next[7];
      end

      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            k_reg     <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          k_reg <= k_reg + 1'b1;
          if (k_reg == KW'(N_PAIRS - 1)) begin
            flush_cnt_reg <= '0;
            state_reg     <= FLUSH;
          end
        end
        FLUSH: begin
          flush_cnt_reg <= flush_cnt_reg + 1'b1;
          if (flush_cnt_reg == 2'd2) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
